// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared fp32 type, default matrix geometry and flat-bus index helpers
package fp_pkg;

    typedef logic [31:0] fp32_t;

    localparam int MAT_ROWS = 4;
    localparam int MAT_COLS = 4;

    // Word position of M[r][c] inside the row-major flattened matrix bus
    function automatic int mat_idx(input int r, input int c, input int cols = MAT_COLS);
        return r * cols + c;
    endfunction

    function automatic int vec_idx(input int c);
        return c;
    endfunction

endpackage

// File: rtl/fp32_mat_vec_issue_if.sv
// rtl/fp32_mat_vec_issue_if.sv - job intake and operand-issue bundle of the mat-vec sequencer
interface fp32_mat_vec_issue_if
    import fp_pkg::*;
#(
    parameter int ROWS  = MAT_ROWS,
    parameter int COLS  = MAT_COLS,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
);

    logic                      valid_in;
    logic                      ready_out;
    logic [ROWS*COLS*32-1:0]   mat_in;
    logic [COLS*32-1:0]        vec_in;
    logic                      stall_in;
    logic                      valid_out;
    fp32_t                     a_out;
    fp32_t                     b_out;
    logic [ROW_W-1:0]          row_out;
    logic [COL_W-1:0]          col_out;
    logic                      row_last_out;
    logic                      job_last_out;
    logic                      busy_out;

    modport master (
        output valid_in, mat_in, vec_in, stall_in,
        input  ready_out, valid_out, a_out, b_out, row_out, col_out,
               row_last_out, job_last_out, busy_out
    );

    modport slave (
        input  valid_in, mat_in, vec_in, stall_in,
        output ready_out, valid_out, a_out, b_out, row_out, col_out,
               row_last_out, job_last_out, busy_out
    );

endinterface

// File: rtl/mat_vec_slot.sv
// rtl/mat_vec_slot.sv - one job register (matrix + vector) with a full flag
module mat_vec_slot #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic                    free,
    input  logic [ROWS*COLS*32-1:0] mat_d,
    input  logic [COLS*32-1:0]      vec_d,
    output logic                    full,
    output logic [ROWS*COLS*32-1:0] mat_q,
    output logic [COLS*32-1:0]      vec_q
);

    // load and free never target the same slot on one edge; load wins defensively
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full  <= 1'b0;
            mat_q <= '0;
            vec_q <= '0;
        end else if (load) begin
            full  <= 1'b1;
            mat_q <= mat_d;
            vec_q <= vec_d;
        end else if (free) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/fp32_mat_vec_issue.sv
// rtl/fp32_mat_vec_issue.sv - ping-pong job buffer issuing row-major (M[r][c], v[c]) pairs to the fp32 multiplier
module fp32_mat_vec_issue
    import fp_pkg::*;
#(
    parameter int ROWS  = MAT_ROWS,
    parameter int COLS  = MAT_COLS,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    fp32_mat_vec_issue_if.slave bus
);

    localparam int MAT_W = ROWS * COLS * 32;
    localparam int VEC_W = COLS * 32;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        full;
    logic [1:0]        load;
    logic [1:0]        free;
    logic [MAT_W-1:0]  mat_q [2];
    logic [VEC_W-1:0]  vec_q [2];
    logic [MAT_W-1:0]  rd_mat;
    logic [VEC_W-1:0]  rd_vec;
    fp32_t             m_sel [ROWS][COLS];
    fp32_t             v_sel [COLS];

    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic              ready;
    logic              accept;
    logic              issue;
    logic              at_row_last;
    logic              at_job_last;

    logic              valid_q;
    fp32_t             a_q;
    fp32_t             b_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic              row_last_q;
    logic              job_last_q;

    assign ready       = ~(full[0] & full[1]);
    assign accept      = bus.valid_in & ready;
    assign issue       = full[rd_ptr] & ~bus.stall_in;
    assign at_row_last = (col_cnt == COL_LAST);
    assign at_job_last = at_row_last && (row_cnt == ROW_LAST);

    // Ping-pong invariant: wr_ptr == rd_ptr only when both slots are empty or both full
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            load[s] = accept && (wr_ptr == 1'(s));
            free[s] = issue && at_job_last && (rd_ptr == 1'(s));
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_slot
        mat_vec_slot #(
            .ROWS (ROWS),
            .COLS (COLS)
        ) u_slot (
            .clk    (clk_in),
            .resetn (rst_in),
            .load   (load[s]),
            .free   (free[s]),
            .mat_d  (bus.mat_in),
            .vec_d  (bus.vec_in),
            .full   (full[s]),
            .mat_q  (mat_q[s]),
            .vec_q  (vec_q[s])
        );
    end

    assign rd_mat = mat_q[rd_ptr];
    assign rd_vec = vec_q[rd_ptr];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign m_sel[r][c] = rd_mat[mat_idx(r, c, COLS)*32 +: 32];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_vec
        assign v_sel[c] = rd_vec[vec_idx(c)*32 +: 32];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_last_q <= 1'b0;
            job_last_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            // Stall or empty read slot: only valid drops, data and tags hold
            if (issue) begin
                valid_q    <= 1'b1;
                a_q        <= m_sel[row_cnt][col_cnt];
                b_q        <= v_sel[col_cnt];
                row_q      <= row_cnt;
                col_q      <= col_cnt;
                row_last_q <= at_row_last;
                job_last_q <= at_job_last;
                if (at_job_last) begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                    rd_ptr  <= ~rd_ptr;
                end else if (at_row_last) begin
                    row_cnt <= row_cnt + 1'b1;
                    col_cnt <= '0;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.ready_out    = ready;
    assign bus.valid_out    = valid_q;
    assign bus.a_out        = a_q;
    assign bus.b_out        = b_q;
    assign bus.row_out      = row_q;
    assign bus.col_out      = col_q;
    assign bus.row_last_out = row_last_q;
    assign bus.job_last_out = job_last_q;
    assign bus.busy_out     = full[0] | full[1] | valid_q;

endmodule

// File: tb/tb_fp32_mat_vec_issue.sv
// tb/tb_fp32_mat_vec_issue.sv - directed self-checking bench for fp32_mat_vec_issue (4x4 and 3x2 builds)
module tb_fp32_mat_vec_issue;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    fp32_mat_vec_issue_if #(.ROWS(4), .COLS(4)) bus4 ();
    fp32_mat_vec_issue_if #(.ROWS(3), .COLS(2)) bus32 ();

    fp32_mat_vec_issue #(.ROWS(4), .COLS(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus4)
    );

    fp32_mat_vec_issue #(.ROWS(3), .COLS(2)) dut32 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus32)
    );

    function automatic fp32_t pat_m(input int seed, input int r, input int c);
        return 32'hA000_0000 | (seed << 16) | (r << 4) | c;
    endfunction

    function automatic fp32_t pat_v(input int seed, input int c);
        return 32'hB000_0000 | (seed << 16) | c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job4(input int seed);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus4.mat_in[mat_idx(r, c, 4)*32 +: 32] = pat_m(seed, r, c);
        for (int c = 0; c < 4; c++)
            bus4.vec_in[vec_idx(c)*32 +: 32] = pat_v(seed, c);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({bus4.valid_out, bus4.row_last_out, bus4.job_last_out} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 000", {bus4.valid_out, bus4.row_last_out, bus4.job_last_out});
        end
        n_cmp++;
        if ({bus4.a_out, bus4.b_out} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 0", {bus4.a_out, bus4.b_out});
        end
        n_cmp++;
        if ({bus4.row_out, bus4.col_out} !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_tags: got %h expected 0", {bus4.row_out, bus4.col_out});
        end
        n_cmp++;
        if ({bus4.ready_out, bus4.busy_out} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_ready_busy: got %b expected 10", {bus4.ready_out, bus4.busy_out});
        end
        n_cmp++;
        if ({bus32.ready_out, bus32.valid_out} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_small: got %b expected 10", {bus32.ready_out, bus32.valid_out});
        end
    endtask

    task automatic test_identity();
        fp32_t vals [4];
        fp32_t ea;
        vals[0] = 32'h3F80_0000;
        vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000;
        vals[3] = 32'h4080_0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus4.mat_in[mat_idx(r, c, 4)*32 +: 32] = (r == c) ? 32'h3F80_0000 : 32'h0;
        for (int c = 0; c < 4; c++)
            bus4.vec_in[vec_idx(c)*32 +: 32] = vals[c];
        bus4.valid_in = 1'b1;
        step();
        bus4.valid_in = 1'b0;
        n_cmp++;
        if (bus4.valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL ident_latency: valid_out got %b expected 0 on accept edge", bus4.valid_out);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            ea = ((i / 4) == (i % 4)) ? 32'h3F80_0000 : 32'h0;
            n_cmp++;
            if ({bus4.valid_out, bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out,
                 bus4.row_last_out, bus4.job_last_out} !==
                {1'b1, ea, vals[i % 4], 2'(i / 4), 2'(i % 4), (i % 4) == 3, i == 15}) begin
                n_bad++;
                $display("FAIL ident_pair%0d: got v%b a%h b%h r%0d c%0d rl%b jl%b expected a%h b%h",
                         i, bus4.valid_out, bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out,
                         bus4.row_last_out, bus4.job_last_out, ea, vals[i % 4]);
            end
        end
        step();
        n_cmp++;
        if ({bus4.valid_out, bus4.busy_out} !== 2'b00) begin
            n_bad++;
            $display("FAIL ident_drain: valid/busy got %b expected 00", {bus4.valid_out, bus4.busy_out});
        end
    endtask

    task automatic test_back_to_back();
        int jp = 0;
        int nval = 0;
        int first = -1;
        int last = -1;
        int acc_t [3];
        int job, i;
        bit acc;
        acc_t[0] = -1; acc_t[1] = -1; acc_t[2] = -1;
        for (int t = 1; t <= 52; t++) begin
            if (jp < 3) begin
                bus4.valid_in = 1'b1;
                load_job4(jp + 1);
            end else begin
                bus4.valid_in = 1'b0;
            end
            acc = bus4.valid_in && bus4.ready_out;
            step();
            if (acc) begin
                acc_t[jp] = t;
                jp++;
            end
            if (t >= 2 && t <= 17) begin
                n_cmp++;
                if (bus4.ready_out !== (t == 17)) begin
                    n_bad++;
                    $display("FAIL b2b_ready_t%0d: got %b expected %b", t, bus4.ready_out, t == 17);
                end
            end
            if (bus4.valid_out === 1'b1) begin
                job = nval / 16 + 1;
                i = nval % 16;
                n_cmp++;
                if ({bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out, bus4.row_last_out, bus4.job_last_out} !==
                    {pat_m(job, i / 4, i % 4), pat_v(job, i % 4), 2'(i / 4), 2'(i % 4), (i % 4) == 3, i == 15}) begin
                    n_bad++;
                    $display("FAIL b2b_pair%0d: got a%h b%h r%0d c%0d expected a%h b%h",
                             nval, bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out,
                             pat_m(job, i / 4, i % 4), pat_v(job, i % 4));
                end
                if (first < 0) first = t;
                last = t;
                nval++;
            end
        end
        bus4.valid_in = 1'b0;
        n_cmp++;
        if ({acc_t[0], acc_t[1], acc_t[2]} !== {32'sd1, 32'sd2, 32'sd18}) begin
            n_bad++;
            $display("FAIL b2b_accept_cycles: got %0d %0d %0d expected 1 2 18", acc_t[0], acc_t[1], acc_t[2]);
        end
        n_cmp++;
        if (nval !== 48 || (last - first + 1) !== 48) begin
            n_bad++;
            $display("FAIL b2b_count_gap: got %0d pairs over %0d cycles expected 48 over 48", nval, last - first + 1);
        end
    endtask

    task automatic test_stall();
        int nval = 0;
        int stall_left = 0;
        int stalled = 0;
        int first = -1;
        int last = -1;
        load_job4(4);
        bus4.valid_in = 1'b1;
        step();
        bus4.valid_in = 1'b0;
        for (int t = 0; t < 30; t++) begin
            bus4.stall_in = (stall_left > 0);
            step();
            if (bus4.stall_in) begin
                stall_left--;
                stalled++;
                n_cmp++;
                if ({bus4.valid_out, bus4.a_out, bus4.row_out, bus4.col_out} !== {1'b0, pat_m(4, 1, 1), 2'd1, 2'd1}) begin
                    n_bad++;
                    $display("FAIL stall_hold%0d: got v%b a%h r%0d c%0d expected v0 a%h r1 c1",
                             stalled, bus4.valid_out, bus4.a_out, bus4.row_out, bus4.col_out, pat_m(4, 1, 1));
                end
            end
            if (bus4.valid_out === 1'b1) begin
                n_cmp++;
                if ({bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out} !==
                    {pat_m(4, nval / 4, nval % 4), pat_v(4, nval % 4), 2'(nval / 4), 2'(nval % 4)}) begin
                    n_bad++;
                    $display("FAIL stall_pair%0d: got a%h b%h r%0d c%0d expected a%h b%h",
                             nval, bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out,
                             pat_m(4, nval / 4, nval % 4), pat_v(4, nval % 4));
                end
                if (nval == 5) stall_left = 3;
                if (first < 0) first = t;
                last = t;
                nval++;
            end
        end
        bus4.stall_in = 1'b0;
        n_cmp++;
        if (nval !== 16 || stalled !== 3 || (last - first + 1) !== 19) begin
            n_bad++;
            $display("FAIL stall_totals: got %0d pairs %0d stalls span %0d expected 16 3 19",
                     nval, stalled, last - first + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int stray = 0;
        load_job4(5);
        bus4.valid_in = 1'b1;
        step();
        load_job4(6);
        step();
        bus4.valid_in = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus4.valid_out === 1'b1 && bus4.row_out === 2'd2 && bus4.col_out === 2'd1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL rstmid_reach_i9: got no pair i=9 within 30 cycles expected one");
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_cmp++;
        if ({bus4.valid_out, bus4.ready_out, bus4.busy_out, bus4.a_out} !== {3'b010, 32'h0}) begin
            n_bad++;
            $display("FAIL rstmid_after: got v%b rdy%b busy%b a%h expected v0 rdy1 busy0 a0",
                     bus4.valid_out, bus4.ready_out, bus4.busy_out, bus4.a_out);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus4.valid_out !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL rstmid_no_pairs: got %0d stray pairs expected 0", stray);
        end
        load_job4(7);
        bus4.valid_in = 1'b1;
        step();
        bus4.valid_in = 1'b0;
        step();
        n_cmp++;
        if ({bus4.valid_out, bus4.a_out, bus4.b_out, bus4.row_out, bus4.col_out} !==
            {1'b1, pat_m(7, 0, 0), pat_v(7, 0), 4'h0}) begin
            n_bad++;
            $display("FAIL rstmid_new_job: got v%b a%h b%h expected v1 a%h b%h",
                     bus4.valid_out, bus4.a_out, bus4.b_out, pat_m(7, 0, 0), pat_v(7, 0));
        end
        repeat (20) step();
    endtask

    task automatic test_small();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                bus32.mat_in[mat_idx(r, c, 2)*32 +: 32] = pat_m(8, r, c);
        for (int c = 0; c < 2; c++)
            bus32.vec_in[vec_idx(c)*32 +: 32] = pat_v(8, c);
        bus32.valid_in = 1'b1;
        step();
        bus32.valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({bus32.valid_out, bus32.a_out, bus32.b_out, bus32.row_out, bus32.col_out,
                 bus32.row_last_out, bus32.job_last_out} !==
                {1'b1, pat_m(8, i / 2, i % 2), pat_v(8, i % 2), 2'(i / 2), 1'(i % 2), (i % 2) == 1, i == 5}) begin
                n_bad++;
                $display("FAIL small_pair%0d: got v%b a%h b%h r%0d c%0d rl%b jl%b expected a%h b%h",
                         i, bus32.valid_out, bus32.a_out, bus32.b_out, bus32.row_out, bus32.col_out,
                         bus32.row_last_out, bus32.job_last_out, pat_m(8, i / 2, i % 2), pat_v(8, i % 2));
            end
        end
        step();
        n_cmp++;
        if (bus32.valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL small_end: valid_out got %b expected 0", bus32.valid_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.valid_in  = 1'b0;
        bus4.stall_in  = 1'b0;
        bus4.mat_in    = '0;
        bus4.vec_in    = '0;
        bus32.valid_in = 1'b0;
        bus32.stall_in = 1'b0;
        bus32.mat_in   = '0;
        bus32.vec_in   = '0;
        test_reset();
        test_identity();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
